// File: rtl/controle_ula_md.sv
// ALU control decoder with a sequential RV32M multiply/divide unit.
// The unit runs shift-add multiply and restoring divide, one bit per cycle.
module controle_ula_md #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [1:0]      iALUOp,
  input  logic [6:0]      iFunct7,
  input  logic [2:0]      iFunct3,
  input  logic            iValid,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic [OPW-1:0]  oALUControl,
  output logic            oIsMd,
  output logic            oMdBusy,
  output logic            oMdDone,
  output logic [XLEN-1:0] oMdResult
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [OPW-1:0] OPAND  = OPW'(0);
  localparam logic [OPW-1:0] OPOR   = OPW'(1);
  localparam logic [OPW-1:0] OPADD  = OPW'(2);
  localparam logic [OPW-1:0] OPSUB  = OPW'(6);
  localparam logic [OPW-1:0] OPSLT  = OPW'(7);
  localparam logic [OPW-1:0] OPLUI  = OPW'(8);
  localparam logic [OPW-1:0] OPNULL = OPW'(31);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;

  assign oIsMd = (iALUOp == 2'b10) && (iFunct7 == 7'b0000001);

  always_comb begin
    oALUControl = OPNULL;
    unique case (iALUOp)
      2'b00: oALUControl = OPADD;
      2'b01: oALUControl = OPSUB;
      2'b11: oALUControl = OPLUI;
      default: begin
        if (iFunct7 == 7'b0000000) begin
          unique case (iFunct3)
            3'b000:  oALUControl = OPADD;
            3'b010:  oALUControl = OPSLT;
            3'b110:  oALUControl = OPOR;
            3'b111:  oALUControl = OPAND;
            default: oALUControl = OPNULL;
          endcase
        end else if (iFunct7 == 7'b0100000 && iFunct3 == 3'b000) begin
          oALUControl = OPSUB;
        end
      end
    endcase
  end

  // Operand signedness per funct3, then magnitudes for the unsigned core
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div0, ovf;

  always_comb begin
    a_sgn = iFunct3[2] ? ~iFunct3[0] : (iFunct3[1:0] != 2'b11);
    b_sgn = iFunct3[2] ? ~iFunct3[0] : ~iFunct3[1];
    a_neg = a_sgn & iA[XLEN-1];
    b_neg = b_sgn & iB[XLEN-1];
    a_mag = a_neg ? -iA : iA;
    b_mag = b_neg ? -iB : iB;
    div0  = iFunct3[2] && (iB == '0);
    ovf   = iFunct3[2] && !iFunct3[0] && (iA == MIN_NEG) && (iB == '1);
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_sh, div_diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] step_nxt;
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   mul_res, div_val, div_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
             + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: upper half is the partial remainder, lower half the quotient
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_nxt  = div_diff[XLEN]
             ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
             : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step_nxt = (state_q == S_DIV) ? div_nxt : mul_nxt;
    mul_fix  = neg_q ? -step_nxt : step_nxt;
    mul_res  = (f3_q == 3'b000) ? mul_fix[XLEN-1:0]
                                : mul_fix[2*XLEN-1:XLEN];
    div_val  = f3_q[1] ? step_nxt[2*XLEN-1:XLEN] : step_nxt[XLEN-1:0];
    div_res  = neg_q ? -div_val : div_val;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (iValid && oIsMd) begin
          a_d   = a_mag;
          b_d   = b_mag;
          f3_d  = iFunct3;
          neg_d = (iFunct3[2] & iFunct3[1]) ? a_neg : (a_neg ^ b_neg);
          acc_d = {{XLEN{1'b0}}, (iFunct3[2] ? a_mag : b_mag)};
          cnt_d = CW'(XLEN - 1);
          if (div0) begin
            state_d = S_DONE;
            res_d   = iFunct3[1] ? iA : '1;
          end else if (ovf) begin
            state_d = S_DONE;
            res_d   = iFunct3[1] ? '0 : iA;
          end else begin
            state_d = iFunct3[2] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = step_nxt;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          res_d   = (state_q == S_MUL) ? mul_res : div_res;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign oMdDone   = (state_q == S_DONE);
  assign oMdResult = res_q;
  assign oMdBusy   = ((state_q == S_IDLE) && iValid && oIsMd)
                   || (state_q == S_MUL) || (state_q == S_DIV);

endmodule

// File: tb/tb_controle_ula_md.sv
// Scoreboard bench for controle_ula_md: directed decode and RV32M vectors.
// Expected results/latencies are queued at issue; a monitor checks on oMdDone.
module tb_controle_ula_md;

  localparam int XLEN = 32;
  localparam int OPW  = 5;

  localparam logic [4:0] E_AND  = 5'd0;
  localparam logic [4:0] E_OR   = 5'd1;
  localparam logic [4:0] E_ADD  = 5'd2;
  localparam logic [4:0] E_SUB  = 5'd6;
  localparam logic [4:0] E_SLT  = 5'd7;
  localparam logic [4:0] E_LUI  = 5'd8;
  localparam logic [4:0] E_NULL = 5'd31;

  logic            iCLK = 1'b0;
  logic            iRST = 1'b0;
  logic [1:0]      iALUOp = 2'b00;
  logic [6:0]      iFunct7 = 7'd0;
  logic [2:0]      iFunct3 = 3'd0;
  logic            iValid = 1'b0;
  logic [XLEN-1:0] iA = '0;
  logic [XLEN-1:0] iB = '0;
  logic [OPW-1:0]  oALUControl;
  logic            oIsMd, oMdBusy, oMdDone;
  logic [XLEN-1:0] oMdResult;

  controle_ula_md #(.XLEN(XLEN), .OPW(OPW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iALUOp(iALUOp), .iFunct7(iFunct7),
    .iFunct3(iFunct3), .iValid(iValid), .iA(iA), .iB(iB),
    .oALUControl(oALUControl), .oIsMd(oIsMd), .oMdBusy(oMdBusy),
    .oMdDone(oMdDone), .oMdResult(oMdResult)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge iCLK) begin
    if (oMdDone) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(cyc), 64'(-1));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, 64'(oMdResult), 64'(e.res));
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic dec(input string name, input logic [1:0] op,
                     input logic [6:0] f7, input logic [2:0] f3,
                     input logic [4:0] exp_ctl, input logic exp_md);
    @(posedge iCLK); #1;
    iALUOp = op; iFunct7 = f7; iFunct3 = f3; iValid = 1'b0;
    @(negedge iCLK);
    chk({name, "_ctl"}, 64'(oALUControl), 64'(exp_ctl));
    chk({name, "_ismd"}, 64'(oIsMd), 64'(exp_md));
  endtask

  task automatic run_md(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int bcnt;
    bit seen;
    exp_t e;
    @(posedge iCLK); #1;
    iALUOp = 2'b10; iFunct7 = 7'b0000001;
    iFunct3 = f3; iA = a; iB = b; iValid = 1'b1;
    e.res = exp; e.at = cyc + lat; e.name = name;
    sb.push_back(e);
    bcnt = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge iCLK);
      if (oMdBusy) bcnt++;
      if (oMdDone) seen = 1;
      else begin
        @(posedge iCLK); #1;
        iValid  = 1'($urandom);
        iFunct3 = 3'($urandom);
        iA      = $urandom;
        iB      = $urandom;
      end
    end
    iValid = 1'b0;
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_busy_cycles"}, 64'(bcnt), 64'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b1;
    @(negedge iCLK);
    chk("reset_busy", 64'(oMdBusy), 64'd0);
    chk("reset_done", 64'(oMdDone), 64'd0);
    chk("reset_result", 64'(oMdResult), 64'd0);

    dec("add", 2'b10, 7'b0000000, 3'b000, E_ADD, 1'b0);
    @(posedge iCLK); #1 iValid = 1'b1;
    @(negedge iCLK);
    chk("add_valid_busy", 64'(oMdBusy), 64'd0);
    chk("add_valid_ctl", 64'(oALUControl), 64'(E_ADD));
    dec("sub", 2'b10, 7'b0100000, 3'b000, E_SUB, 1'b0);
    dec("slt", 2'b10, 7'b0000000, 3'b010, E_SLT, 1'b0);
    dec("or", 2'b10, 7'b0000000, 3'b110, E_OR, 1'b0);
    dec("and", 2'b10, 7'b0000000, 3'b111, E_AND, 1'b0);
    dec("rnull", 2'b10, 7'b0000000, 3'b001, E_NULL, 1'b0);
    dec("load", 2'b00, 7'b0100000, 3'b010, E_ADD, 1'b0);
    dec("branch", 2'b01, 7'b0000000, 3'b000, E_SUB, 1'b0);
    dec("lui", 2'b11, 7'b0000001, 3'b111, E_LUI, 1'b0);
    dec("mdnull", 2'b10, 7'b0000001, 3'b000, E_NULL, 1'b1);

    run_md("mul_7_m3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_md("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_md("mulh_ff", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33);
    run_md("mulhsu_ff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_md("mulhu_2p16", 3'b011, 32'h10000, 32'h10000, 32'h1, 33);
    run_md("div_by0", 3'b100, 32'd100, 32'd0, 32'hFFFFFFFF, 1);
    run_md("rem_by0", 3'b110, 32'd100, 32'd0, 32'd100, 1);
    run_md("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_md("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_md("divu_m7_2", 3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33);
    run_md("remu_m7_2", 3'b111, 32'hFFFFFFF9, 32'd2, 32'd1, 33);
    run_md("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_md("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    run_md("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_md("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_md("div_min_1", 3'b100, 32'h80000000, 32'd1, 32'h80000000, 33);
    run_md("rem_m100_7", 3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);
    run_md("div_100_m7", 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);

    // Abort a divide mid-flight with reset
    @(posedge iCLK); #1;
    iALUOp = 2'b10; iFunct7 = 7'b0000001;
    iFunct3 = 3'b100; iA = 32'd1000; iB = 32'd3; iValid = 1'b1;
    @(posedge iCLK); #1 iValid = 1'b0;
    repeat (9) @(posedge iCLK);
    #1 iRST = 1'b0;
    @(posedge iCLK); #1 iRST = 1'b1;
    @(negedge iCLK);
    chk("abort_busy", 64'(oMdBusy), 64'd0);
    chk("abort_done", 64'(oMdDone), 64'd0);
    chk("abort_result", 64'(oMdResult), 64'd0);
    run_md("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    repeat (4) @(posedge iCLK);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/controle_ula_md.md
CONTROLE_ULA_MD -- requirements
Module: controle_ula_md

Interface
REQ-001 XLEN, default 32, datapath and operand width.
REQ-002 OPW, default 5, width of the ALU control code.
REQ-003 iCLK  input  1  system clock; all state updates on the rising edge.
REQ-004 iRST  input  1  one clock; reset is synchronous and active-low.
REQ-005 iALUOp  input  2  operation class from the main control (00 load/store/addi, 01 branch, 10 R-type, 11 LUI).
REQ-006 iFunct7  input  7  instruction funct7 field.
REQ-007 iFunct3  input  3  instruction funct3 field.
REQ-008 iValid  input  1  instruction present and executing this cycle.
REQ-009 iA, iB  input  XLEN each  rs1/rs2 operands.
REQ-010 oALUControl  output  OPW  operation code for the single-cycle ALU.
REQ-011 oIsMd  output  1  current instruction is RV32M (iALUOp=10, iFunct7=0000001).
REQ-012 oMdBusy  output  1  stall request to PC and register-file write enable.
REQ-013 oMdDone  output  1  one-cycle pulse: oMdResult valid, write it back.
REQ-014 oMdResult  output  XLEN  multiply/divide result.

Function
REQ-015 Decode is combinational: 00 -> OPADD; 01 -> OPSUB; 11 -> OPLUI; 10 with funct3 000/funct7 0000000 -> OPADD, funct3 000/funct7 0100000 -> OPSUB, 010 -> OPSLT, 110 -> OPOR, 111 -> OPAND; any other R-type non-M combination -> OPNULL.
REQ-016 When oIsMd=1, oALUControl = OPNULL; the operation is executed by the internal sequential unit.
REQ-017 M funct3 map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-018 FSM states: IDLE, MUL, DIV, DONE.
REQ-019 Accept: in IDLE with iValid=1 and oIsMd=1 (cycle T), latch iA, iB and funct3; go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-020 MUL: radix-2 shift-add on 2*XLEN-bit product using operand magnitudes, sign-corrected per op; exactly XLEN iterations, then DONE.
REQ-021 DIV: restoring division on magnitudes, quotient/remainder sign-corrected (quotient negative iff signs differ, remainder takes dividend sign); exactly XLEN iterations, then DONE.
REQ-022 Normal latency: oMdDone=1 in cycle T+XLEN+1 (DONE state); DONE returns to IDLE next cycle.
REQ-023 MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN] with signed*signed, signed*unsigned, unsigned*unsigned operands respectively.
REQ-024 Divide by zero: skip iterations, DONE at T+1; DIV/DIVU -> all ones, REM/REMU -> dividend.
REQ-025 Signed overflow (DIV/REM, dividend = most-negative, divisor = -1): DONE at T+1; DIV -> dividend, REM -> 0.
REQ-026 oMdBusy = (IDLE and iValid and oIsMd) or state in {MUL, DIV}; low in DONE so the instruction retires that cycle.
REQ-027 iA, iB, iFunct3, iValid changes during MUL/DIV/DONE are ignored; no new accept until IDLE.
REQ-028 oMdResult holds its last value until the next DONE; oMdDone high only in DONE.
REQ-029 Iteration counter is ceil(log2(XLEN))+1 bits, counts XLEN-1 down to 0, no wrap.

Reset
REQ-030 iRST=0 at a rising edge forces IDLE, counter 0, internal registers 0, oMdResult=0, oMdDone=0, oMdBusy=0 (unless REQ-026 combinational term asserts), regardless of state, including mid-operation.
REQ-031 No accept occurs in a cycle where iRST=0.

Verification
REQ-032 iALUOp=10, funct3=000, funct7=0000000, iValid=1 -> oALUControl=OPADD, oIsMd=0, oMdBusy=0; funct7=0100000 -> OPSUB.
REQ-033 MUL iA=7, iB=0xFFFFFFFD at T -> oMdBusy high T..T+32, oMdDone at T+33, oMdResult=0xFFFFFFEB.
REQ-034 MULHU iA=iB=0xFFFFFFFF -> oMdResult=0xFFFFFFFE at T+33; MULH same operands -> 0x00000000.
REQ-035 DIV iA=100, iB=0 -> oMdDone at T+1, result 0xFFFFFFFF; REM same -> 100; DIVU -7/2 (0xFFFFFFF9,2) -> 0x7FFFFFFC at T+33.
REQ-036 DIV iA=0x80000000, iB=0xFFFFFFFF -> 0x80000000 at T+1; REM -> 0; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-037 iRST=0 at T+10 of a DIV -> next cycle IDLE, oMdBusy=0, oMdDone=0, oMdResult=0; a following MUL 3*4 completes with 12 at its T+33.
